neural_unit_sequencer: RTL and testbench
========================================

# neural_unit_sequencer

Control sequencer for one four-input neural unit: it accepts a job request, loads four 8-bit weights into the unit's weight bank one per cycle, and pulses the sum trigger. It then waits for layer done and returns the captured layer output through a valid/ready result port. It sits between the layer-level scheduler and a single neural unit, and owns the unit's weight, address, write, sum-trigger and layer-select pins.

## Interface
Parameters:
- WEIGHT_W, 8, width of one weight
- DATA_W, 32, width of layer output
- TIMEOUT_CYCLES, 255, cycles in WAIT before a timeout is declared (used only with NU_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  job request
- start_ready  out  1  high exactly when the block is in IDLE
- start_weights  in  4*WEIGHT_W  packed weights; weight k is at [k*WEIGHT_W +: WEIGHT_W]
- start_skip_load  in  1  reuse the weights currently in the bank
- start_layer_sel  in  1  0 = raw sum, 1 = Elliot-activated output
- nu_weight  out  WEIGHT_W  weight-bank write data
- nu_address  out  2  weight-bank address
- nu_write  out  1  weight-bank write strobe
- nu_sum_trigger  out  1  one-cycle summer start pulse
- nu_layer_sel  out  1  layer mux select
- nu_layer_out  in  DATA_W  unit result
- nu_layer_done  in  1  unit result valid
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  DATA_W  captured result
- res_timeout  out  1  result produced by watchdog
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, SETTLE, TRIGGER, WAIT, RESULT.
- Start handshake: IDLE with start_valid=1. It registers the weights, skip flag and layer_sel.
  - Next state is LOAD, or SETTLE when start_skip_load=1 and weights_loaded=1.
  - start_skip_load with weights_loaded=0 is ignored, and LOAD is performed.
- LOAD: 2-bit counter 0..3. Drives nu_address=counter, nu_weight=weight[counter] and nu_write=1 for 4 consecutive cycles. Exits to SETTLE after address 3. Sets weights_loaded=1 on exit.
- SETTLE: one cycle so the registered shifters see the new weights.
- TRIGGER: nu_sum_trigger=1 for exactly one cycle, then WAIT.
- WAIT: samples nu_layer_done. On the first cycle it is high, captures nu_layer_out into res_data, sets res_timeout=0 and goes to RESULT.
- RESULT: res_valid=1, with res_data and res_timeout held stable until res_ready=1. On that handshake the block returns to IDLE.
- nu_layer_sel is registered at the start handshake and held until the next accepted job.
- nu_write and nu_sum_trigger are 0 outside LOAD and TRIGGER respectively.
- nu_weight and nu_address are 0 outside LOAD.
- Upstream holds the unit's data inputs stable while busy=1; this block does not drive them.

## Timing
- Reset values:
  - state IDLE, so start_ready=1 and busy=0.
  - nu_weight=0, nu_address=0, nu_write=0, nu_sum_trigger=0, nu_layer_sel=0.
  - res_valid=0, res_data=0, res_timeout=0, weights_loaded=0.
- Accept in cycle 0:
  - Full load: LOAD in cycles 1–4, SETTLE in cycle 5, nu_sum_trigger in cycle 6.
  - Skip load: SETTLE in cycle 1, nu_sum_trigger in cycle 2.
- nu_layer_done is ignored in TRIGGER. The earliest capture is the first WAIT cycle, and res_valid rises the cycle after capture.
- res_ready high while res_valid=0 has no effect. res_valid and res_ready both high in cycle N puts start_ready=1 in cycle N+1. There is no same-cycle result-to-start bypass.
- Reset asserted mid-operation:
  - Outputs return to their reset values immediately (asynchronous); nu_write drops with no completion of the write.
  - weights_loaded clears, because the bank contents are unknown.
  - A pending result is discarded.

## Configuration
- NU_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on entry.
  - If it reaches TIMEOUT_CYCLES with no done, the block goes to RESULT with res_data=0 and res_timeout=1.
  - A done arriving on the same cycle as the timeout wins: the data is captured and res_timeout=0.
- NU_SEQ_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely.
  - res_timeout is constant 0. TIMEOUT_CYCLES is unused.

## Test plan
- Full load: weights 0x04030201, layer_sel=1, nu_layer_done raised 3 cycles after trigger with nu_layer_out=0x00001234 -> nu_write high in cycles 1–4 with address/weight (0,0x01),(1,0x02),(2,0x03),(3,0x04); trigger in cycle 6; res_valid with res_data=0x00001234 and nu_layer_sel=1 held throughout.
- Skip load after a completed job -> no nu_write pulses; trigger in cycle 2. Skip load right after reset -> a full 4-write load occurs.
- Backpressure: res_ready low for 5 cycles -> res_valid and res_data stable throughout; start_ready stays 0; IDLE is reached one cycle after res_ready rises.
- Reset pulsed on the second LOAD cycle -> nu_write=0 immediately, start_ready=1; a following skip-load job still performs a full load.
- With NU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, done never raised -> res_valid with res_timeout=1 and res_data=0. Done raised on the cycle the count reaches 10 -> res_timeout=0 and the data is captured.
- Without NU_SEQ_TIMEOUT_EN, done withheld 1000 cycles -> block remains in WAIT with busy=1 and res_timeout=0; done then completes the job normally.

Source files
------------

// File: rtl/neural_unit_sequencer.sv
// neural_unit_sequencer
// Control sequencer for one four-input neural unit. It accepts a job, writes
// four weights into the unit's weight bank (one per cycle), pulses the sum
// trigger, waits for the unit's layer_done, and returns the captured output
// through a valid/ready result port.
//
// Optional feature: define NU_SEQ_TIMEOUT_EN to add a WAIT-state watchdog
// that completes the job with res_data=0 and res_timeout=1 once the counter
// reaches TIMEOUT_CYCLES with no layer_done.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_*           job request (valid/ready), packed weights, skip-load
//                     flag, layer select
//   nu_*              weight bank write pins, sum trigger, layer select,
//                     unit result and done inputs
//   res_*             result port (valid/ready), data and timeout flag
//   busy              high in every state except IDLE
module neural_unit_sequencer #(
  parameter int unsigned WEIGHT_W       = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [4*WEIGHT_W-1:0] start_weights,
  input  logic                  start_skip_load,
  input  logic                  start_layer_sel,
  output logic [WEIGHT_W-1:0]   nu_weight,
  output logic [1:0]            nu_address,
  output logic                  nu_write,
  output logic                  nu_sum_trigger,
  output logic                  nu_layer_sel,
  input  logic [DATA_W-1:0]     nu_layer_out,
  input  logic                  nu_layer_done,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic                  res_timeout,
  output logic                  busy
);

  localparam int unsigned NUM_W  = 4;
  localparam int unsigned BANK_W = NUM_W * WEIGHT_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_TRIGGER = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [BANK_W-1:0]   weights_q, weights_d;
  logic                loaded_q, loaded_d;
  logic                start_ready_q, start_ready_d;
  logic                busy_q, busy_d;
  logic [WEIGHT_W-1:0] nu_weight_q, nu_weight_d;
  logic [1:0]          nu_address_q, nu_address_d;
  logic                nu_write_q, nu_write_d;
  logic                nu_sum_trigger_q, nu_sum_trigger_d;
  logic                nu_layer_sel_q, nu_layer_sel_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_timeout_q, res_timeout_d;

`ifdef NU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Select weight idx out of the packed bank.
  function automatic logic [WEIGHT_W-1:0] pick_weight(input logic [BANK_W-1:0] bank,
                                                       input logic [1:0]        idx);
    pick_weight = bank[idx*WEIGHT_W +: WEIGHT_W];
  endfunction

  // Next-state logic; unit pins are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    weights_d      = weights_q;
    loaded_d       = loaded_q;
    nu_layer_sel_d = nu_layer_sel_q;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;
    res_timeout_d  = res_timeout_q;
`ifdef NU_SEQ_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          weights_d      = start_weights;
          nu_layer_sel_d = start_layer_sel;
          cnt_d          = 2'd0;
          // A skip request is honoured only when the bank holds known weights.
          if (start_skip_load && loaded_q) state_d = S_SETTLE;
          else                             state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == 2'd3) begin
          state_d  = S_SETTLE;
          loaded_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_SETTLE: begin
        state_d = S_TRIGGER;
      end
      S_TRIGGER: begin
        state_d = S_WAIT;
`ifdef NU_SEQ_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (nu_layer_done) begin
          res_data_d    = nu_layer_out;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = S_RESULT;
        end
`ifdef NU_SEQ_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = S_RESULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    nu_write_d       = (state_d == S_LOAD);
    nu_address_d     = nu_write_d ? cnt_d : 2'd0;
    nu_weight_d      = nu_write_d ? pick_weight(weights_d, cnt_d) : '0;
    nu_sum_trigger_d = (state_d == S_TRIGGER);
    start_ready_d    = (state_d == S_IDLE);
    busy_d           = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= 2'd0;
      weights_q        <= '0;
      loaded_q         <= 1'b0;
      start_ready_q    <= 1'b1;
      busy_q           <= 1'b0;
      nu_weight_q      <= '0;
      nu_address_q     <= 2'd0;
      nu_write_q       <= 1'b0;
      nu_sum_trigger_q <= 1'b0;
      nu_layer_sel_q   <= 1'b0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      weights_q        <= weights_d;
      loaded_q         <= loaded_d;
      start_ready_q    <= start_ready_d;
      busy_q           <= busy_d;
      nu_weight_q      <= nu_weight_d;
      nu_address_q     <= nu_address_d;
      nu_write_q       <= nu_write_d;
      nu_sum_trigger_q <= nu_sum_trigger_d;
      nu_layer_sel_q   <= nu_layer_sel_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
      res_timeout_q    <= res_timeout_d;
    end
  end

`ifdef NU_SEQ_TIMEOUT_EN
  // Watchdog counter, only meaningful in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign start_ready    = start_ready_q;
  assign busy           = busy_q;
  assign nu_weight      = nu_weight_q;
  assign nu_address     = nu_address_q;
  assign nu_write       = nu_write_q;
  assign nu_sum_trigger = nu_sum_trigger_q;
  assign nu_layer_sel   = nu_layer_sel_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_timeout    = res_timeout_q;

endmodule

// File: tb/tb_neural_unit_sequencer.sv
// Self-checking bench for neural_unit_sequencer: randomized jobs compared
// cycle by cycle against a schedule derived from the job-level timing rules.
module tb_neural_unit_sequencer;

`ifdef NU_SEQ_TIMEOUT_EN
  localparam int unsigned TO_CYC = 10;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] start_weights;
  logic        start_skip_load;
  logic        start_layer_sel;
  logic [7:0]  nu_weight;
  logic [1:0]  nu_address;
  logic        nu_write;
  logic        nu_sum_trigger;
  logic        nu_layer_sel;
  logic [31:0] nu_layer_out;
  logic        nu_layer_done;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: does the bank hold known weights, last layer_sel.
  bit model_loaded = 1'b0;
  bit prev_sel     = 1'b0;

  neural_unit_sequencer #(
    .WEIGHT_W(8), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_weights(start_weights), .start_skip_load(start_skip_load),
    .start_layer_sel(start_layer_sel),
    .nu_weight(nu_weight), .nu_address(nu_address), .nu_write(nu_write),
    .nu_sum_trigger(nu_sum_trigger), .nu_layer_sel(nu_layer_sel),
    .nu_layer_out(nu_layer_out), .nu_layer_done(nu_layer_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run one job; done_dly<0 means layer_done is never raised.
  task automatic run_job(input logic [31:0] w, input bit skip, input bit sel,
                         input int done_dly, input logic [31:0] data,
                         input int ready_dly, input bit noise);
    bit          load;
    bit          exp_to;
    int          t_trig, tc, tr;
    logic [31:0] exp_data;
    logic [12:0] exp_pins, got_pins;
    logic [33:0] exp_res, got_res;
    logic [1:0]  exp_hs, got_hs;
    bit          e_wr, e_val;
    logic [7:0]  e_wt;
    logic [1:0]  e_ad;

    load     = !(skip && model_loaded);
    t_trig   = load ? 6 : 2;
    exp_to   = 1'b0;
    exp_data = data;
`ifdef NU_SEQ_TIMEOUT_EN
    if (done_dly < 0 || done_dly > int'(TO_CYC) + 1) begin
      tc       = t_trig + int'(TO_CYC) + 1;
      exp_to   = 1'b1;
      exp_data = 32'h0;
    end else begin
      tc = t_trig + done_dly;
    end
`else
    tc = t_trig + done_dly;
`endif
    tr = tc + 1 + ready_dly;

    // Cycle 0: request presented while idle.
    start_valid     = 1'b1;
    start_weights   = w;
    start_skip_load = skip;
    start_layer_sel = sel;
    @(negedge clk);
    n_cmp++;
    if ({start_ready, busy, nu_layer_sel} !== {1'b1, 1'b0, prev_sel}) begin
      n_err++;
      $display("FAIL accept_idle: got ready/busy/sel=%b expected %b",
               {start_ready, busy, nu_layer_sel}, {1'b1, 1'b0, prev_sel});
    end
    @(posedge clk); #1;
    start_valid     = 1'b0;
    start_weights   = $urandom;
    start_skip_load = 1'($urandom_range(0, 1));
    start_layer_sel = 1'($urandom_range(0, 1));

    for (int c = 1; c <= tr + 1; c++) begin
      nu_layer_done = ((c == tc) && !exp_to) || (noise && (c == t_trig));
      nu_layer_out  = (c == tc) ? data : $urandom;
      res_ready     = (c == tr) ? 1'b1 : ((c <= tc) ? 1'($urandom_range(0, 1)) : 1'b0);

      e_wr  = load && (c >= 1) && (c <= 4);
      e_ad  = e_wr ? 2'(c - 1) : 2'd0;
      e_wt  = e_wr ? w[(c-1)*8 +: 8] : 8'h00;
      e_val = (c > tc) && (c <= tr);

      exp_pins = {e_wr, e_ad, e_wt, (c == t_trig), sel};
      exp_res  = {e_val, e_val ? exp_to : 1'b0, e_val ? exp_data : 32'h0};
      exp_hs   = {(c > tr), !(c > tr)};

      @(negedge clk);
      got_pins = {nu_write, nu_address, nu_weight, nu_sum_trigger, nu_layer_sel};
      got_res  = {res_valid, res_valid ? res_timeout : res_timeout,
                  res_valid ? res_data : 32'h0};
      if (!e_val) got_res[32] = res_timeout;
      n_cmp++;
      if (got_pins !== exp_pins) begin
        n_err++;
        $display("FAIL pins c=%0d: got wr/ad/wt/trg/sel=%h expected %h", c, got_pins, exp_pins);
      end
      n_cmp++;
      if (got_res !== exp_res) begin
        n_err++;
        $display("FAIL result c=%0d: got vld/to/data=%h expected %h", c, got_res, exp_res);
      end
      n_cmp++;
      if ({start_ready, busy} !== exp_hs) begin
        n_err++;
        $display("FAIL handshake c=%0d: got ready/busy=%b expected %b", c, {start_ready, busy}, exp_hs);
      end
      @(posedge clk); #1;
    end
    nu_layer_done = 1'b0;
    res_ready     = 1'b0;
    model_loaded  = 1'b1;
    prev_sel      = sel;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if ({start_ready, busy, nu_weight, nu_address, nu_write, nu_sum_trigger, nu_layer_sel,
         res_valid, res_data, res_timeout} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0,
         1'b0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: ready=%b busy=%b wr=%b trg=%b vld=%b data=%h to=%b",
               start_ready, busy, nu_write, nu_sum_trigger, res_valid, res_data, res_timeout);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({start_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_after_reset: got ready/busy=%b expected 10", {start_ready, busy});
    end
  endtask

  task automatic test_skip_after_reset();
    run_job($urandom, 1'b1, 1'b0, 2, $urandom, 1, 1'b0);
  endtask

  task automatic test_full_load();
    run_job(32'h04030201, 1'b0, 1'b1, 3, 32'h00001234, 0, 1'b0);
  endtask

  task automatic test_skip_load();
    run_job($urandom, 1'b1, 1'b1, 1, $urandom, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_job($urandom, 1'b0, 1'b0, 4, $urandom, 5, 1'b0);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 24; j++)
      run_job($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 6)), $urandom, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w;
    w = $urandom;
    start_valid     = 1'b1;
    start_weights   = w;
    start_skip_load = 1'b0;
    start_layer_sel = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({nu_write, nu_address, nu_weight} !== {1'b1, 2'd1, w[15:8]}) begin
      n_err++;
      $display("FAIL second_load_cycle: got wr/ad/wt=%h expected %h",
               {nu_write, nu_address, nu_weight}, {1'b1, 2'd1, w[15:8]});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({nu_write, nu_address, nu_weight, start_ready, busy, nu_layer_sel} !==
        {1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got wr/ad/wt/rdy/busy/sel=%h expected %h",
               {nu_write, nu_address, nu_weight, start_ready, busy, nu_layer_sel},
               {1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    rst_n        = 1'b1;
    model_loaded = 1'b0;
    prev_sel     = 1'b0;
    run_job($urandom, 1'b1, 1'b0, 2, $urandom, 0, 1'b0);
  endtask

`ifdef NU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_job($urandom, 1'b1, 1'b1, -1, $urandom, 2, 1'b0);
    run_job($urandom, 1'b1, 1'b0, int'(TO_CYC) + 1, $urandom, 1, 1'b0);
    run_job($urandom, 1'b0, 1'b1, int'(TO_CYC), $urandom, 0, 1'b0);
  endtask
`else
  task automatic test_long_wait();
    run_job($urandom, 1'b1, 1'b1, 1000, $urandom, 1, 1'b0);
  endtask
`endif

  initial begin
    rst_n           = 1'b0;
    start_valid     = 1'b0;
    start_weights   = 32'h0;
    start_skip_load = 1'b0;
    start_layer_sel = 1'b0;
    nu_layer_out    = 32'h0;
    nu_layer_done   = 1'b0;
    res_ready       = 1'b0;
    test_reset();
    test_skip_after_reset();
    test_full_load();
    test_skip_load();
    test_backpressure();
    test_random_jobs();
    test_reset_mid_load();
`ifdef NU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
